// File: rtl/lcd_ctrl_gen_pkg.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_gen_pkg
// Shared definitions for the LCD image controller:
//   - cmd_e    : 4-bit command codes accepted on the command strobe
//   - state_e  : controller sequencing states
//   - CMD_W    : command field width
//   - cmd_is_reserved() : true for the unassigned codes D..F
// No ports (package). The optional error output is controlled by the
// LCD_CTRL_GEN_ERR_EN macro in the interface and top files.
// -----------------------------------------------------------------------------
package lcd_ctrl_gen_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE    = 4'h0,
    CMD_UP       = 4'h1,
    CMD_DOWN     = 4'h2,
    CMD_LEFT     = 4'h3,
    CMD_RIGHT    = 4'h4,
    CMD_MAX      = 4'h5,
    CMD_MIN      = 4'h6,
    CMD_AVG      = 4'h7,
    CMD_ROT_CCW  = 4'h8,
    CMD_ROT_CW   = 4'h9,
    CMD_MIRROR_X = 4'hA,
    CMD_MIRROR_Y = 4'hB,
    CMD_RECENTRE = 4'hC
  } cmd_e;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  // Codes above the last defined command do nothing but still take a cycle.
  function automatic logic cmd_is_reserved(input logic [CMD_W-1:0] code);
    return code > CMD_RECENTRE;
  endfunction

endpackage

// File: rtl/lcd_ctrl_gen_if.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_gen_if
// Bundles every non-clock/reset signal of the LCD controller.
//   Parameters: DW (pixel width), AW (pixel address width)
//   Command side : cmd, cmd_valid (host -> ctrl), busy, done (ctrl -> host)
//   IROM side    : IROM_rd, IROM_A (ctrl -> rom), IROM_Q (rom -> ctrl)
//   IRAM side    : IRAM_valid, IRAM_A, IRAM_D (ctrl -> ram)
//   cmd_err      : only present when LCD_CTRL_GEN_ERR_EN is defined
// Modports: master = the controller, slave = host plus memories.
// -----------------------------------------------------------------------------
interface lcd_ctrl_gen_if
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 6
) ();

  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             busy;
  logic             done;
  logic             IROM_rd;
  logic [AW-1:0]    IROM_A;
  logic [DW-1:0]    IROM_Q;
  logic             IRAM_valid;
  logic [DW-1:0]    IRAM_D;
  logic [AW-1:0]    IRAM_A;
`ifdef LCD_CTRL_GEN_ERR_EN
  logic             cmd_err;
`endif

  modport master (
    input  cmd, cmd_valid, IROM_Q,
`ifdef LCD_CTRL_GEN_ERR_EN
    output cmd_err,
`endif
    output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
`ifdef LCD_CTRL_GEN_ERR_EN
    input  cmd_err,
`endif
    input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A
  );

endinterface

// File: rtl/lcd_ctrl_gen_win_alu.sv
// -----------------------------------------------------------------------------
// lcd_win_alu
// Purely combinational 2x2 window operator. Given the window
//     [a b]
//     [c d]
// and a command code, produces the replacement values a_o..d_o.
//   cmd_i           : command code
//   a_i, b_i, c_i, d_i : current window pixels
//   a_o, b_o, c_o, d_o : new window pixels (pass-through for non-pixel cmds)
// -----------------------------------------------------------------------------
module lcd_win_alu
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  logic [DW-1:0]    c_i,
  input  logic [DW-1:0]    d_i,
  output logic [DW-1:0]    a_o,
  output logic [DW-1:0]    b_o,
  output logic [DW-1:0]    c_o,
  output logic [DW-1:0]    d_o
);

  logic [DW-1:0] maxAb, maxCd, maxAll;
  logic [DW-1:0] minAb, minCd, minAll;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;

  // Reductions are two-level trees; the sum carries two extra bits so four
  // full-scale pixels never wrap before the divide by four.
  always_comb begin
    maxAb  = (a_i > b_i) ? a_i : b_i;
    maxCd  = (c_i > d_i) ? c_i : d_i;
    maxAll = (maxAb > maxCd) ? maxAb : maxCd;
    minAb  = (a_i < b_i) ? a_i : b_i;
    minCd  = (c_i < d_i) ? c_i : d_i;
    minAll = (minAb < minCd) ? minAb : minCd;
    sum    = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i} + {2'b00, d_i};
    avg    = sum[DW+1:2];
  end

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    d_o = d_i;
    case (cmd_i)
      CMD_MAX: begin
        a_o = maxAll; b_o = maxAll; c_o = maxAll; d_o = maxAll;
      end
      CMD_MIN: begin
        a_o = minAll; b_o = minAll; c_o = minAll; d_o = minAll;
      end
      CMD_AVG: begin
        a_o = avg; b_o = avg; c_o = avg; d_o = avg;
      end
      CMD_ROT_CCW: begin
        a_o = b_i; b_o = d_i; c_o = a_i; d_o = c_i;
      end
      CMD_ROT_CW: begin
        a_o = c_i; b_o = a_i; c_o = d_i; d_o = b_i;
      end
      CMD_MIRROR_X: begin
        a_o = c_i; b_o = d_i; c_o = a_i; d_o = b_i;
      end
      CMD_MIRROR_Y: begin
        a_o = b_i; b_o = a_i; c_o = d_i; d_o = c_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_gen
// LCD image controller: loads an IMG_W x IMG_H image from IROM, applies 2x2
// window commands around a movable origin, and dumps the image to IRAM.
//   Parameters: DW (pixel width), IMG_W / IMG_H (powers of two, >= 2)
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : lcd_ctrl_gen_if.master (command, IROM and IRAM signals)
// Optional: define LCD_CTRL_GEN_ERR_EN to add bus.cmd_err, a one-cycle flag
// raised during the execute cycle of a reserved code or a blocked shift.
// -----------------------------------------------------------------------------
module lcd_ctrl_gen
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic            clk,
  input logic            reset,
  lcd_ctrl_gen_if.master bus
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_MIN     = XW'(1);
  localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_CTR     = XW'(IMG_W / 2);
  localparam logic [YW-1:0] Y_MIN     = YW'(1);
  localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_CTR     = YW'(IMG_H / 2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  state_e           state_q;
  logic [CMD_W-1:0] cmd_q;
  logic             busy_q;
  logic             done_q;
  logic             iromRd_q;
  logic [AW-1:0]    iromAddr_q;
  logic             iramValid_q;
  logic [AW-1:0]    iramAddr_q;
  logic [DW-1:0]    iramData_q;
  logic [XW-1:0]    ox_q;
  logic [YW-1:0]    oy_q;
  logic [DW-1:0]    img_q [N];

  logic [XW-1:0]    oxM1;
  logic [YW-1:0]    oyM1;
  logic [AW-1:0]    addrA, addrB, addrC, addrD;
  logic [DW-1:0]    winA_d, winB_d, winC_d, winD_d;
  logic [AW-1:0]    iramAddrNext;

  // Power-of-two dimensions make the row-major address a plain {y, x} concat.
  assign oxM1  = ox_q - XW'(1);
  assign oyM1  = oy_q - YW'(1);
  assign addrA = {oyM1, oxM1};
  assign addrB = {oyM1, ox_q};
  assign addrC = {oy_q, oxM1};
  assign addrD = {oy_q, ox_q};
  assign iramAddrNext = iramAddr_q + AW'(1);

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd_i (cmd_q),
    .a_i   (img_q[addrA]),
    .b_i   (img_q[addrB]),
    .c_i   (img_q[addrC]),
    .d_i   (img_q[addrD]),
    .a_o   (winA_d),
    .b_o   (winB_d),
    .c_o   (winC_d),
    .d_o   (winD_d)
  );

`ifdef LCD_CTRL_GEN_ERR_EN
  logic cmdIsErr;
  logic cmdErr_q;

  // Evaluated on the incoming command so the flag can be registered on the
  // accept edge and line up with the single execute cycle.
  always_comb begin
    cmdIsErr = cmd_is_reserved(bus.cmd);
    case (bus.cmd)
      CMD_UP:    cmdIsErr = (oy_q == Y_MIN);
      CMD_DOWN:  cmdIsErr = (oy_q == Y_MAX);
      CMD_LEFT:  cmdIsErr = (ox_q == X_MIN);
      CMD_RIGHT: cmdIsErr = (ox_q == X_MAX);
      default: ;
    endcase
  end

  assign bus.cmd_err = cmdErr_q;
`endif

  // Whole controller: sequencing, image array, origin and both address sweeps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      cmd_q       <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      iromRd_q    <= 1'b0;
      iromAddr_q  <= '0;
      iramValid_q <= 1'b0;
      iramAddr_q  <= '0;
      iramData_q  <= '0;
      ox_q        <= X_CTR;
      oy_q        <= Y_CTR;
`ifdef LCD_CTRL_GEN_ERR_EN
      cmdErr_q    <= 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
        img_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // First cycle only raises the read strobe; each later cycle captures
        // the word addressed on the previous one, so the final capture edge
        // is also the edge that leaves the state.
        S_LOAD: begin
          if (iromRd_q) begin
            img_q[iromAddr_q] <= bus.IROM_Q;
            if (iromAddr_q == LAST_ADDR) begin
              iromRd_q   <= 1'b0;
              iromAddr_q <= '0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              iromAddr_q <= iromAddr_q + AW'(1);
            end
          end else begin
            iromRd_q <= 1'b1;
          end
        end

        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q  <= bus.cmd;
            busy_q <= 1'b1;
            if (bus.cmd == CMD_WRITE) begin
              iramValid_q <= 1'b1;
              iramAddr_q  <= '0;
              iramData_q  <= img_q[0];
              state_q     <= S_WRITE;
            end else begin
`ifdef LCD_CTRL_GEN_ERR_EN
              cmdErr_q <= cmdIsErr;
`endif
              state_q  <= S_EXEC;
            end
          end
        end

        // The ALU passes pixels through for non-pixel commands, so the window
        // write-back is harmless for shifts, re-centre and reserved codes.
        S_EXEC: begin
          img_q[addrA] <= winA_d;
          img_q[addrB] <= winB_d;
          img_q[addrC] <= winC_d;
          img_q[addrD] <= winD_d;
          case (cmd_q)
            CMD_UP:       if (oy_q != Y_MIN) oy_q <= oy_q - YW'(1);
            CMD_DOWN:     if (oy_q != Y_MAX) oy_q <= oy_q + YW'(1);
            CMD_LEFT:     if (ox_q != X_MIN) ox_q <= ox_q - XW'(1);
            CMD_RIGHT:    if (ox_q != X_MAX) ox_q <= ox_q + XW'(1);
            CMD_RECENTRE: begin
              ox_q <= X_CTR;
              oy_q <= Y_CTR;
            end
            default: ;
          endcase
`ifdef LCD_CTRL_GEN_ERR_EN
          cmdErr_q <= 1'b0;
`endif
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        // Data is fetched one address ahead so IRAM_D matches IRAM_A.
        S_WRITE: begin
          if (iramAddr_q == LAST_ADDR) begin
            iramValid_q <= 1'b0;
            iramAddr_q  <= '0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            iramAddr_q <= iramAddrNext;
            iramData_q <= img_q[iramAddrNext];
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.IROM_rd    = iromRd_q;
  assign bus.IROM_A     = iromAddr_q;
  assign bus.IRAM_valid = iramValid_q;
  assign bus.IRAM_D     = iramData_q;
  assign bus.IRAM_A     = iramAddr_q;

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl_gen
// Scoreboard bench for lcd_ctrl_gen. Two instances share clock and reset:
//   dut1 : default 8x8, DW=8,  IROM word i = i
//   dut2 : 16x4,        DW=10, IROM word i = 1023 - i
// Each WRITE pushes the expected 64 (address, pixel) pairs; a negedge monitor
// pops one per IRAM write. Define LCD_CTRL_GEN_ERR_EN to also check cmd_err.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl_gen;
  import lcd_ctrl_gen_pkg::*;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int failures = 0;
  int done1Count = 0;
  int done2Count = 0;
  int expErrCount = 0;
  int seenErrCount = 0;

  exp_t q1[$];
  exp_t q2[$];
  int   exp1 [64];
  int   exp2 [64];

  lcd_ctrl_gen_if #(.DW(8),  .AW(6)) if1 ();
  lcd_ctrl_gen_if #(.DW(10), .AW(6)) if2 ();

  lcd_ctrl_gen #(.DW(8), .IMG_W(8), .IMG_H(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  lcd_ctrl_gen #(.DW(10), .IMG_W(16), .IMG_H(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  always #5 clk = ~clk;

  // IROM models: update on the falling edge while read is enabled.
  always @(negedge clk) begin
    if (if1.IROM_rd) if1.IROM_Q <= 8'(if1.IROM_A);
    if (if2.IROM_rd) if2.IROM_Q <= 10'(10'd1023 - {4'b0000, if2.IROM_A});
  end

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // IRAM-side monitors: one expected entry consumed per captured write.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.IRAM_valid) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_iram_write", 1, 0);
      end else begin
        e = q1.pop_front();
        check($sformatf("dut1_iram_addr[%0d]", e.addr), if1.IRAM_A, e.addr);
        check($sformatf("dut1_iram_data[%0d]", e.addr), if1.IRAM_D, e.data);
      end
    end
    if (if1.done) done1Count++;
`ifdef LCD_CTRL_GEN_ERR_EN
    if (if1.cmd_err) seenErrCount++;
    if (if2.cmd_err) seenErrCount++;
`endif
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (if2.IRAM_valid) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_iram_write", 1, 0);
      end else begin
        e = q2.pop_front();
        check($sformatf("dut2_iram_addr[%0d]", e.addr), if2.IRAM_A, e.addr);
        check($sformatf("dut2_iram_data[%0d]", e.addr), if2.IRAM_D, e.data);
      end
    end
    if (if2.done) done2Count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveCmd(input int sel, input logic [3:0] code, input logic valid);
    if (sel == 0) begin
      if1.cmd = code;
      if1.cmd_valid = valid;
    end else begin
      if2.cmd = code;
      if2.cmd_valid = valid;
    end
  endtask

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? if1.busy : if2.busy;
  endfunction

`ifdef LCD_CTRL_GEN_ERR_EN
  function automatic logic errOf(input int sel);
    return (sel == 0) ? if1.cmd_err : if2.cmd_err;
  endfunction
`endif

  // Issue one command once the target is idle; non-WRITE commands must hold
  // busy for exactly one cycle.
  task automatic applyStimulus(input int sel, input logic [3:0] code, input logic expErr);
    int guard = 0;
    while (busyOf(sel) && guard < 300) begin
      tick();
      guard++;
    end
    check($sformatf("dut%0d_idle_before_cmd%0h", sel + 1, code), busyOf(sel), 0);
    if (expErr) expErrCount++;
    driveCmd(sel, code, 1'b1);
    tick();
    driveCmd(sel, code, 1'b0);
    check($sformatf("dut%0d_busy_on_accept_cmd%0h", sel + 1, code), busyOf(sel), 1);
    if (code != CMD_WRITE) begin
`ifdef LCD_CTRL_GEN_ERR_EN
      check($sformatf("dut%0d_cmd_err_cmd%0h", sel + 1, code), errOf(sel), expErr);
`endif
      tick();
      check($sformatf("dut%0d_busy_after_exec_cmd%0h", sel + 1, code), busyOf(sel), 0);
    end
  endtask

  task automatic pushImage(input int sel);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.addr = i;
      e.data = (sel == 0) ? exp1[i] : exp2[i];
      if (sel == 0) q1.push_back(e);
      else          q2.push_back(e);
    end
  endtask

  // WRITE with optional attempt to slip a MIN command in while busy.
  task automatic writeImage(input int sel, input bit inject);
    int startDone;
    int guard = 0;
    startDone = (sel == 0) ? done1Count : done2Count;
    pushImage(sel);
    applyStimulus(sel, CMD_WRITE, 1'b0);
    if (inject) begin
      repeat (5) tick();
      driveCmd(sel, CMD_MIN, 1'b1);
      tick();
      driveCmd(sel, CMD_MIN, 1'b0);
    end
    while (busyOf(sel) && guard < 300) begin
      tick();
      guard++;
    end
    check($sformatf("dut%0d_write_completes", sel + 1), busyOf(sel), 0);
    check($sformatf("dut%0d_done_pulses_once", sel + 1),
          ((sel == 0) ? done1Count : done2Count) - startDone, 1);
    check($sformatf("dut%0d_all_writes_seen", sel + 1),
          (sel == 0) ? q1.size() : q2.size(), 0);
  endtask

  task automatic checkResetValues();
    check("dut1_rst_busy",       if1.busy, 1);
    check("dut1_rst_done",       if1.done, 0);
    check("dut1_rst_irom_rd",    if1.IROM_rd, 0);
    check("dut1_rst_iram_valid", if1.IRAM_valid, 0);
    check("dut1_rst_irom_a",     if1.IROM_A, 0);
    check("dut1_rst_iram_a",     if1.IRAM_A, 0);
    check("dut2_rst_busy",       if2.busy, 1);
    check("dut2_rst_iram_valid", if2.IRAM_valid, 0);
`ifdef LCD_CTRL_GEN_ERR_EN
    check("dut1_rst_cmd_err",    if1.cmd_err, 0);
`endif
  endtask

  // Release reset and measure cycles until busy drops on each instance.
  task automatic waitLoad();
    int k1 = 0;
    int k2 = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 1) begin
        check("dut1_load_rd_first", if1.IROM_rd, 1);
        check("dut1_load_addr_first", if1.IROM_A, 0);
      end
      if (k == 2) check("dut1_load_addr_second", if1.IROM_A, 1);
      if (k1 == 0 && !if1.busy) k1 = k;
      if (k2 == 0 && !if2.busy) k2 = k;
      if (k1 != 0 && k2 != 0) break;
    end
    check("dut1_load_cycles", k1, 65);
    check("dut2_load_cycles", k2, 65);
    check("dut1_irom_rd_after_load", if1.IROM_rd, 0);
  endtask

  task automatic resetModels();
    for (int i = 0; i < 64; i++) begin
      exp1[i] = i;
      exp2[i] = 1023 - i;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    int guard;
    reset = 1'b0;
    driveCmd(0, 4'h0, 1'b0);
    driveCmd(1, 4'h0, 1'b0);
    resetModels();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    waitLoad();

    // --- dut1: identity dump, with a command attempted while busy
    writeImage(0, 1'b1);

    // Rotate CW on the centre window 27,28 / 35,36
    applyStimulus(0, CMD_ROT_CW, 1'b0);
    exp1[27] = 35; exp1[28] = 27; exp1[35] = 36; exp1[36] = 28;
    writeImage(0, 1'b0);

    // CCW undoes CW, mirror X twice is identity, mirror Y swaps columns
    applyStimulus(0, CMD_ROT_CCW, 1'b0);
    applyStimulus(0, CMD_MIRROR_X, 1'b0);
    applyStimulus(0, CMD_MIRROR_X, 1'b0);
    applyStimulus(0, CMD_MIRROR_Y, 1'b0);
    exp1[27] = 28; exp1[28] = 27; exp1[35] = 36; exp1[36] = 35;
    applyStimulus(0, 4'hD, 1'b1);
    applyStimulus(0, 4'hF, 1'b1);
    writeImage(0, 1'b0);

    // MAX at centre, then MIN one step down-right (window 36,37,44,45)
    applyStimulus(0, CMD_MAX, 1'b0);
    exp1[27] = 36; exp1[28] = 36; exp1[35] = 36; exp1[36] = 36;
    applyStimulus(0, CMD_DOWN, 1'b0);
    applyStimulus(0, CMD_RIGHT, 1'b0);
    applyStimulus(0, CMD_MIN, 1'b0);
    exp1[37] = 36; exp1[44] = 36; exp1[45] = 36;
    applyStimulus(0, CMD_UP, 1'b0);
    applyStimulus(0, CMD_LEFT, 1'b0);
    writeImage(0, 1'b0);

    // Clamp at (1,1), then AVG of 0,1,8,9 = floor(18/4) = 4
    applyStimulus(0, CMD_UP, 1'b0);
    applyStimulus(0, CMD_UP, 1'b0);
    applyStimulus(0, CMD_UP, 1'b0);
    applyStimulus(0, CMD_UP, 1'b1);
    applyStimulus(0, CMD_LEFT, 1'b0);
    applyStimulus(0, CMD_LEFT, 1'b0);
    applyStimulus(0, CMD_LEFT, 1'b0);
    applyStimulus(0, CMD_LEFT, 1'b1);
    applyStimulus(0, CMD_AVG, 1'b0);
    exp1[0] = 4; exp1[1] = 4; exp1[8] = 4; exp1[9] = 4;
    writeImage(0, 1'b0);

    // --- dut2 (16x4): MIN at centre (8,2), window 23,24,39,40 -> 983
    applyStimulus(1, CMD_MIN, 1'b0);
    exp2[23] = 983; exp2[24] = 983; exp2[39] = 983; exp2[40] = 983;
    writeImage(1, 1'b0);

    // Wander to (10,1) with one blocked up, re-centre, step left to (7,2):
    // AVG of 1001,983,985,983 = floor(3952/4) = 988 (sum exceeds 10 bits)
    applyStimulus(1, CMD_RIGHT, 1'b0);
    applyStimulus(1, CMD_RIGHT, 1'b0);
    applyStimulus(1, CMD_UP, 1'b0);
    applyStimulus(1, CMD_UP, 1'b1);
    applyStimulus(1, CMD_RECENTRE, 1'b0);
    applyStimulus(1, CMD_LEFT, 1'b0);
    applyStimulus(1, CMD_AVG, 1'b0);
    exp2[22] = 988; exp2[23] = 988; exp2[38] = 988; exp2[39] = 988;
    writeImage(1, 1'b0);

    // --- Abort a dut1 WRITE at pixel 20 with an asynchronous reset
    pushImage(0);
    applyStimulus(0, CMD_WRITE, 1'b0);
    guard = 0;
    while (if1.IRAM_A != 6'd20 && guard < 100) begin
      tick();
      guard++;
    end
    check("dut1_abort_reached_pixel20", if1.IRAM_A, 20);
    #2;
    reset = 1'b0;
    #1;
    check("dut1_abort_busy",       if1.busy, 1);
    check("dut1_abort_iram_valid", if1.IRAM_valid, 0);
    check("dut1_abort_iram_a",     if1.IRAM_A, 0);
    check("dut1_abort_done",       if1.done, 0);
    check("dut1_abort_irom_rd",    if1.IROM_rd, 0);
    q1.delete();
    repeat (2) @(posedge clk);
    doneBefore = done1Count;
    resetModels();
    waitLoad();
    check("dut1_no_done_during_reload", done1Count - doneBefore, 0);
    writeImage(0, 1'b0);
    writeImage(1, 1'b0);

    check("dut1_queue_empty_at_end", q1.size(), 0);
    check("dut2_queue_empty_at_end", q2.size(), 0);
`ifdef LCD_CTRL_GEN_ERR_EN
    check("cmd_err_pulse_total", seenErrCount, expErrCount);
`endif
    $display("[TB] error-flagged commands issued: %0d", expErrCount);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
